// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and transmitter.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO; a push into a full FIFO is dropped and
// flagged unless a pop frees a slot in the same cycle.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [DATA_BITS-1:0]       push_data_i,
   input  logic                       pop_i,
   output logic [DATA_BITS-1:0]       data_o,
   output logic [$clog2(FIFO_DEPTH):0] count_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic                       overrun_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_q;
   logic [AW-1:0]        rd_q;
   logic [CW-1:0]        cnt_q;
   logic                 ovr_q;
   logic                 pop_ok;
   logic                 push_ok;

   assign full_o    = (cnt_q == CW'(FIFO_DEPTH));
   assign empty_o   = (cnt_q == '0);
   assign pop_ok    = pop_i && !empty_o;
   assign push_ok   = push_i && (!full_o || pop_ok);
   assign data_o    = mem_q[rd_q];
   assign count_o   = cnt_q;
   assign overrun_o = ovr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ovr_q <= 1'b0;
      end else begin
         if (push_ok) begin
            mem_q[wr_q] <= push_data_i;
            wr_q        <= wr_q + AW'(1);
         end
         if (pop_ok) begin
            rd_q <= rd_q + AW'(1);
         end
         if (push_ok && !pop_ok) begin
            cnt_q <= cnt_q + CW'(1);
         end else if (pop_ok && !push_ok) begin
            cnt_q <= cnt_q - CW'(1);
         end
         ovr_q <= push_i && !push_ok;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling FSM and a
// receive FIFO presented to the consumer as valid/ready.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        rx,
   output logic [DATA_BITS-1:0]        rx_data,
   output logic                        rx_valid,
   input  logic                        rx_ready,
   output logic                        frame_err,
   output logic                        overrun,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int CNTW = $clog2(CLKS_PER_BIT);
   localparam int IW   = $clog2(DATA_BITS);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CLKS_PER_BIT - 1);
   localparam logic [CNTW-1:0] CNT_HALF = CNTW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IW-1:0]   IDX_LAST = IW'(DATA_BITS - 1);

   logic [1:0]           sync_q;
   logic                 rxs;
   uart_state_e          state_q;
   logic [CNTW-1:0]      cnt_q;
   logic [IW-1:0]        idx_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 frame_err_q;
   logic                 bit_end;
   logic                 push;
   logic                 fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx};
      end
   end

   assign rxs     = sync_q[1];
   assign bit_end = (cnt_q == CNT_LAST);
   // Push straight from the stop sample so the byte lands a cycle earlier.
   assign push    = (state_q == STOP) && bit_end && rxs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         cnt_q       <= cnt_q + CNTW'(1);
         unique case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (!rxs) state_q <= START;
            end
            START: begin
               if (cnt_q == CNT_HALF) begin
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  state_q <= rxs ? IDLE : DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt_q          <= '0;
                  shift_q[idx_q] <= rxs;
                  idx_q          <= idx_q + IW'(1);
                  if (idx_q == IDX_LAST) state_q <= STOP;
               end
            end
            STOP: begin
               if (bit_end) begin
                  cnt_q <= '0;
                  if (rxs) begin
                     state_q <= IDLE;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= WAIT_HIGH;
                  end
               end
            end
            WAIT_HIGH: begin
               cnt_q <= '0;
               if (rxs) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign frame_err = frame_err_q;
   assign rx_valid  = !fifo_empty;

   uart_rx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .push_data_i (shift_q),
      .pop_i       (rx_ready),
      .data_o      (rx_data),
      .count_o     (fifo_count),
      .full_o      (),
      .empty_o     (fifo_empty),
      .overrun_o   (overrun)
   );

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx against a queue-based frame model.
module tb_uart_rx;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
   logic [2:0] fifo_count;

   int n_tests = 0;
   int n_fail  = 0;
   int fe_seen = 0;
   int ov_seen = 0;
   int exp_fe  = 0;
   int exp_ov  = 0;
   int q[$];

   uart_rx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err === 1'b1) fe_seen++;
      if (overrun === 1'b1) ov_seen++;
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One ideal frame; n counts negedges from the start-bit fall.
   // Stop decision edge is the posedge right after negedge 154.
   task automatic send(input logic [7:0] b, input logic stop,
                       input bit pop_at_stop, input int abort_at);
      logic [9:0] bits;
      bit was_empty, pop_ok, do_push;
      int head;
      bits      = {stop, b, 1'b0};
      was_empty = (q.size() == 0);
      pop_ok    = pop_at_stop && !was_empty;
      do_push   = stop && ((q.size() < DEPTH) || pop_ok);
      head      = was_empty ? 0 : q[0];
      for (int n = 0; n < 10 * CPB; n++) begin
         @(negedge clk);
         if (abort_at >= 0 && n == abort_at) return;
         if (n == 154) begin
            chk("valid_pre", rx_valid, !was_empty);
            chk("fe_pre", frame_err, 0);
            chk("ov_pre", overrun, 0);
            if (!was_empty) chk("head_pre", rx_data, head);
            rx_ready = pop_at_stop;
         end
         if (n == 155) begin
            rx_ready = 1'b0;
            chk("fe_pulse", frame_err, !stop);
            chk("ov_pulse", overrun, stop && !do_push);
            if (pop_ok) void'(q.pop_front());
            if (do_push) q.push_back(b);
            if (!stop) exp_fe++;
            if (stop && !do_push) exp_ov++;
            chk("valid_post", rx_valid, q.size() != 0);
         end
         if (n == 156) begin
            chk("fe_end", frame_err, 0);
            chk("ov_end", overrun, 0);
         end
         rx = bits[n / CPB];
      end
      chk("count", fifo_count, q.size());
      if (q.size() != 0) chk("head", rx_data, q[0]);
   endtask

   task automatic drain_all();
      while (q.size() > 0) begin
         chk("drain_valid", rx_valid, 1);
         chk("drain_data", rx_data, q[0]);
         chk("drain_cnt", fifo_count, q.size());
         rx_ready = 1'b1;
         @(negedge clk);
         void'(q.pop_front());
      end
      rx_ready = 1'b0;
      chk("drain_empty", rx_valid, 0);
      chk("drain_zero", fifo_count, 0);
   endtask

   task automatic drain_one();
      if (q.size() > 0) begin
         rx_ready = 1'b1;
         @(negedge clk);
         rx_ready = 1'b0;
         void'(q.pop_front());
         chk("pop1_valid", rx_valid, q.size() != 0);
         chk("pop1_cnt", fifo_count, q.size());
      end
   endtask

   task automatic glitch();
      @(negedge clk);
      rx = 1'b0;
      repeat (3) @(negedge clk);
      @(negedge clk);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      chk("glitch_valid", rx_valid, q.size() != 0);
      chk("glitch_fe", fe_seen, exp_fe);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] b;
      logic       stop;
      rst_n    = 1'b0;
      rx       = 1'b1;
      rx_ready = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_valid", rx_valid, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_fe", frame_err, 0);
      chk("rst_ov", overrun, 0);
      chk("rst_data", rx_data, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      send(8'hA5, 1'b1, 1'b0, -1);
      chk("a5_data", rx_data, 8'hA5);
      drain_one();

      glitch();
      send(8'h3C, 1'b1, 1'b0, -1);
      chk("3c_data", rx_data, 8'h3C);
      drain_all();

      send(8'h5A, 1'b0, 1'b0, -1);
      repeat (40) @(negedge clk);
      chk("brk_count", fifo_count, 0);
      chk("brk_fe_once", fe_seen, exp_fe);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      chk("brk_release", fifo_count, 0);
      send(8'h55, 1'b1, 1'b0, -1);
      chk("55_data", rx_data, 8'h55);
      drain_all();

      for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0, -1);
      chk("ovr_count", fifo_count, 4);
      chk("ovr_pulses", ov_seen, exp_ov);
      drain_all();

      for (int i = 0; i < 4; i++) send(8'($urandom), 1'b1, 1'b0, -1);
      send(8'h77, 1'b1, 1'b1, -1);
      chk("fullpop_count", fifo_count, 4);
      chk("fullpop_tail", q[q.size()-1], 8'h77);
      chk("fullpop_ov", ov_seen, exp_ov);
      drain_all();

      send(8'($urandom), 1'b1, 1'b0, -1);
      send(8'($urandom), 1'b1, 1'b0, -1);
      send(8'hE7, 1'b1, 1'b0, 4 * CPB + 8);
      rst_n = 1'b0;
      rx    = 1'b1;
      #1;
      chk("midrst_count", fifo_count, 0);
      chk("midrst_valid", rx_valid, 0);
      chk("midrst_data", rx_data, 0);
      q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      send(8'hC3, 1'b1, 1'b0, -1);
      chk("c3_data", rx_data, 8'hC3);
      drain_all();

      repeat (24) begin
         b    = 8'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         send(b, stop, bit'($urandom_range(0, 1)), -1);
         if (!stop) begin
            rx = 1'b1;
            repeat (20) @(negedge clk);
         end else begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
         case ($urandom_range(0, 3))
            0: drain_all();
            1: drain_one();
            default: ;
         endcase
      end
      drain_all();

      chk("fe_total", fe_seen, exp_fe);
      chk("ov_total", ov_seen, exp_ov);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the `riscv_top` serial link. It deserialises the 8N1 stream arriving on the board `Rx` pin and hands bytes to the CPU-side I/O logic through a valid/ready interface. It is the counterpart of the UART transmitter that drives `Tx`. A small FIFO absorbs bursts from the host. Framing errors and overruns are reported as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200). Must be ≥ 4 and even. Simulation builds (`SIM=1`) use 16.
- `FIFO_DEPTH`, default 8: receive FIFO entries. Must be a power of 2, ≥ 2.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx` in 1: serial input, asynchronous to `clk`; idle high.
- `rx_data` out 8: FIFO head byte; valid only while `rx_valid` = 1.
- `rx_valid` out 1: FIFO not empty.
- `rx_ready` in 1: consumer accepts the head byte. A pop occurs when `rx_valid && rx_ready`.
- `frame_err` out 1: one-cycle pulse; stop bit sampled 0.
- `overrun` out 1: one-cycle pulse; byte dropped because the FIFO was full.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current occupancy.

## Operation
- `rx` passes through a 2-flop synchroniser. Both flops reset to 1. The synchronised signal is `rxs`.
- The bit counter `cnt` spans 0..CLKS_PER_BIT-1 and the bit index `idx` spans 0..7.
- FSM states:
  - **IDLE**: when `rxs` = 0, go to START with `cnt` = 0.
  - **START**: when `cnt` = CLKS_PER_BIT/2-1, sample `rxs`.
    - If `rxs` = 1, the start was a glitch: return to IDLE with no flag.
    - Otherwise go to DATA with `cnt` = 0 and `idx` = 0.
  - **DATA**: when `cnt` = CLKS_PER_BIT-1, shift `rxs` into bit `idx`. Data is LSB first. After `idx` = 7, go to STOP.
  - **STOP**: when `cnt` = CLKS_PER_BIT-1, sample `rxs`.
    - If `rxs` = 1: push the byte and go to IDLE.
    - If `rxs` = 0: pulse `frame_err`, drop the byte, and go to WAIT_HIGH.
  - **WAIT_HIGH**: when `rxs` = 1, go to IDLE. This prevents a break condition from being taken as a stream of starts.
- FIFO is show-ahead: `rx_data` is the head entry combinationally from the storage array.
- Push when full:
  - If a pop occurs in the same cycle, the push succeeds and there is no overrun.
  - Otherwise the byte is dropped and `overrun` pulses.
- Push and pop in the same cycle on an empty FIFO: the pop is invalid because `rx_valid` = 0, so only the push happens.
- Pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally. `fifo_count` distinguishes full from empty.

## Timing
- Reset values: `rx_valid` = 0, `fifo_count` = 0, `frame_err` = 0, `overrun` = 0, `rx_data` = 0. The FSM starts in IDLE and both counters start at 0.
- Asserting `rst_n` mid-frame discards the partial byte and empties the FIFO immediately, because the reset is asynchronous.
- Let t0 be the first cycle in which `rxs` = 0 while in IDLE. This is 2–3 cycles after the `rx` pin falls. Let H = CLKS_PER_BIT/2 and N = CLKS_PER_BIT.
  - Start-bit check: cycle t0+H.
  - Data bit i sample: cycle t0+H+(i+1)·N.
  - Stop sample and push: cycle t0+H+9N.
  - `rx_valid` rises on t0+H+9N+1 if the FIFO was empty.
  - `frame_err` / `overrun` are high exactly during cycle t0+H+9N+1.
- The FSM is back in IDLE at mid-stop, so a start bit immediately following the stop bit is caught.
- Pop effect: `rx_data` / `fifo_count` update the cycle after the pop edge. If `rx_ready` is held high, one byte is consumed per cycle.

## Structure
- Package `uart_pkg`:
  - `DATA_BITS` = 8.
  - The FSM state enum: IDLE, START, DATA, STOP, WAIT_HIGH.
  - Shared with the transmitter.
- Sub-module `uart_rx_fifo`:
  - Parameterised by `FIFO_DEPTH`.
  - Ports: push / pop / data / count / full / empty.
  - Owns the overrun decision.
- `uart_rx` contains the synchroniser, counters, FSM and shift register.

## Test plan
All scenarios use CLKS_PER_BIT = 16 and FIFO_DEPTH = 4. The bench drives `rx` with an ideal 16-cycle-per-bit model.
- **Reset and single byte.** Hold `rst_n` low with `rx` = 1: all outputs 0. Send 0xA5 with `rx_ready` = 0 → `rx_valid` rises at t0+153 and `rx_data` = 0xA5. Pulse `rx_ready` once → `rx_valid` = 0 and `fifo_count` = 0.
- **Glitch.** Drive `rx` low for 4 cycles, then high → no `rx_valid` and no `frame_err`. The FSM is in IDLE by t0+9. A subsequent 0x3C is received correctly.
- **Framing error.**
  - Send 0x5A with stop bit = 0, then hold `rx` low 40 cycles → exactly one `frame_err` pulse, `fifo_count` stays 0, no new start is detected while low.
  - Release `rx` high, then send 0x55 → `rx_data` = 0x55.
- **Overrun.** With `rx_ready` = 0, send 0x01..0x05 back-to-back → `fifo_count` = 4 and one `overrun` pulse on the 5th byte. Draining yields 0x01, 0x02, 0x03, 0x04.
- **Full with simultaneous pop.** Fill to 4, then assert `rx_ready` for exactly the stop-sample cycle of a 5th byte 0x77 → no overrun, `fifo_count` stays 4, and the last drained byte is 0x77.
- **Reset mid-frame.** Assert `rst_n` low during data bit 3 of a byte, with 2 bytes already queued → FIFO empty immediately. After release, 0xC3 is received correctly.
